// File: rtl/mem_port_arbiter_if.sv
// Request, response and memory-side signals of the shared memory port arbiter.
// Pure wiring bundle: no storage, no added latency.
// Handshakes are level-held requests answered by done pulses, and mem_req answered by mem_ready.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch side
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_done;
    // data side
    logic                  d_req;
    logic                  d_we;
    logic [DATA_W/8-1:0]   d_be;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_done;
    // status towards the pipeline
    logic                  bus_err;
    logic                  stall_if;
    logic                  stall_mem;
    // memory side
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_be;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_ready;
    logic [DATA_W-1:0]     mem_rdata;

    // arbiter view
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ready, mem_rdata,
        output if_rdata, if_done, d_rdata, d_done, bus_err, stall_if, stall_mem,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    // pipeline + memory view
    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ready, mem_rdata,
        input  if_rdata, if_done, d_rdata, d_done, bus_err, stall_if, stall_mem,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters; data wins, with a watchdog abort.
// Latency: done 2 cycles after the request is seen in IDLE, plus one cycle per memory wait state.
// Requesters are stalled until their done pulse; mem_req is held until mem_ready or watchdog expiry.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    mem_port_arbiter_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

    state_t              state_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [BE_W-1:0]     mem_be_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;
    logic                if_done_q;
    logic                d_done_q;
    logic                bus_err_q;
    logic [CNT_W-1:0]    wd_cnt_q;
    logic                wd_fire;

    // watchdog expiry: last allowed wait cycle with memory still silent
    assign wd_fire = (TIMEOUT != 0) && (wd_cnt_q == WD_LAST);

    // arbitration FSM with registered memory-side and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            wd_cnt_q    <= '0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            bus_err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    wd_cnt_q <= '0;
                    // data is the older instruction, so it always wins a tie
                    if (bus.d_req) begin
                        state_q     <= BUSY_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.d_we;
                        mem_be_q    <= bus.d_we ? bus.d_be : '1;
                        mem_addr_q  <= bus.d_addr;
                        mem_wdata_q <= bus.d_wdata;
                    end else if (bus.if_req) begin
                        state_q     <= BUSY_I;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= '1;
                        mem_addr_q  <= bus.if_addr;
                        mem_wdata_q <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (bus.mem_ready) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (state_q == BUSY_I) begin
                            if_rdata_q <= bus.mem_rdata;
                            if_done_q  <= 1'b1;
                            state_q    <= RESP_I;
                        end else begin
                            // a store returns no data, so the last load result survives
                            if (!mem_we_q) begin
                                d_rdata_q <= bus.mem_rdata;
                            end
                            d_done_q <= 1'b1;
                            state_q  <= RESP_D;
                        end
                    end else if (wd_fire) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        bus_err_q <= 1'b1;
                        if (state_q == BUSY_I) begin
                            if_rdata_q <= '0;
                            if_done_q  <= 1'b1;
                            state_q    <= RESP_I;
                        end else begin
                            d_rdata_q <= '0;
                            d_done_q  <= 1'b1;
                            state_q   <= RESP_D;
                        end
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
                end
                // one response cycle; the still-held request is not re-granted from here
                RESP_I, RESP_D: state_q <= IDLE;
                default:        state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.bus_err   = bus_err_q;
    assign bus.stall_if  = bus.if_req & ~if_done_q;
    assign bus.stall_mem = bus.d_req & ~d_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
// Model and compare run every cycle after reset; directed tests pin latencies and data literally.
// Memory responder answers after a programmable number of wait cycles.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int req_cycles = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // ---------------- memory responder ----------------
    int          mem_waits = 0;
    int          rcnt      = 0;
    logic        force_rdy = 1'b0;
    logic [31:0] mem_data  = '0;

    always @(posedge clk) begin
        #1;
        bus.mem_rdata = mem_data;
        if (!bus.mem_req) begin
            rcnt = 0;
            bus.mem_ready = force_rdy;
        end else begin
            bus.mem_ready = (rcnt == mem_waits);
            rcnt++;
        end
    end

    // ---------------- reference model (transaction level) ----------------
    // owner: 0 = port free, 1 = fetch transfer, 2 = data transfer
    int              owner  = 0;
    int              waited = 0;
    bit              showing_result = 1'b0;
    logic            e_req, e_we, e_id, e_dd, e_err;
    logic [BW-1:0]   e_be;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_wdata, e_ir, e_dr;

    always @(posedge clk) begin
        if (rst) begin
            owner = 0; waited = 0; showing_result = 1'b0;
            e_req = 0; e_we = 0; e_be = '0; e_addr = '0; e_wdata = '0;
            e_ir = '0; e_dr = '0; e_id = 0; e_dd = 0; e_err = 0;
        end else begin
            e_id = 0; e_dd = 0; e_err = 0;
            if (owner != 0) begin
                if (bus.mem_ready || (TO != 0 && waited == TO - 1)) begin
                    if (owner == 1) begin
                        e_id = 1;
                        e_ir = bus.mem_ready ? bus.mem_rdata : '0;
                    end else begin
                        e_dd = 1;
                        if (!bus.mem_ready) e_dr = '0;
                        else if (!e_we)     e_dr = bus.mem_rdata;
                    end
                    e_err = !bus.mem_ready;
                    e_req = 0; e_we = 0;
                    owner = 0;
                    showing_result = 1'b1;
                end else begin
                    waited++;
                end
            end else if (showing_result) begin
                showing_result = 1'b0;
            end else if (bus.d_req) begin
                owner = 2; waited = 0;
                e_req = 1; e_we = bus.d_we; e_be = bus.d_we ? bus.d_be : '1;
                e_addr = bus.d_addr; e_wdata = bus.d_wdata;
            end else if (bus.if_req) begin
                owner = 1; waited = 0;
                e_req = 1; e_we = 0; e_be = '1;
                e_addr = bus.if_addr; e_wdata = '0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            if (bus.mem_req) req_cycles++;
            chk("mem_req",   bus.mem_req,   e_req);
            chk("mem_we",    bus.mem_we,    e_we);
            chk("mem_be",    bus.mem_be,    e_be);
            chk("mem_addr",  bus.mem_addr,  e_addr);
            chk("mem_wdata", bus.mem_wdata, e_wdata);
            chk("if_done",   bus.if_done,   e_id);
            chk("d_done",    bus.d_done,    e_dd);
            chk("bus_err",   bus.bus_err,   e_err);
            chk("if_rdata",  bus.if_rdata,  e_ir);
            chk("d_rdata",   bus.d_rdata,   e_dr);
            chk("stall_if",  bus.stall_if,  bus.if_req & ~e_id);
            chk("stall_mem", bus.stall_mem, bus.d_req & ~e_dd);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit data, input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (data ? bus.d_done : bus.if_done) begin
                at = cyc;
                break;
            end
        end
        checks++;
        if (at < 0) begin
            errors++;
            $display("FAIL wait_%s_done: no done pulse within %0d cycles", data ? "d" : "if", maxc);
        end
    endtask

    initial begin
        int t0, at, r0, seen;
        bus.if_req = 0; bus.if_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
        rst = 1'b1;
        step();
        step();
        cmp_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_mem_req", bus.mem_req, 0);
        chk("reset_d_rdata", bus.d_rdata, 0);

        // 1: zero-wait load
        step();
        mem_waits = 0; mem_data = 32'hDEADBEEF;
        bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'h100; bus.d_wdata = '0;
        t0 = cyc; r0 = req_cycles;
        wait_done(1, 20, at);
        chk("t1_done_latency", at - t0, 2);
        chk("t1_d_rdata", bus.d_rdata, 32'hDEADBEEF);
        chk("t1_req_cycles", req_cycles - r0, 1);
        step();
        bus.d_req = 0;

        // 2: simultaneous requests, one wait state each; IF is granted in the IDLE cycle t0+4
        step();
        mem_waits = 1; mem_data = 32'hA5A50001;
        bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'h200;
        bus.if_req = 1; bus.if_addr = 32'h40;
        t0 = cyc;
        wait_done(1, 20, at);
        chk("t2_d_latency", at - t0, 3);
        step();
        bus.d_req = 0;
        wait_done(0, 20, at);
        chk("t2_if_latency", at - t0, 7);
        chk("t2_if_rdata", bus.if_rdata, 32'hA5A50001);
        step();
        bus.if_req = 0;

        // 3: store with partial byte enables
        step();
        mem_waits = 1; mem_data = 32'hBAD0BAD0;
        bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0011; bus.d_addr = 32'h300; bus.d_wdata = 32'h12345678;
        t0 = cyc;
        step();
        @(negedge clk);
        chk("t3_mem_we", bus.mem_we, 1);
        chk("t3_mem_be", bus.mem_be, 4'b0011);
        chk("t3_mem_wdata", bus.mem_wdata, 32'h12345678);
        wait_done(1, 20, at);
        chk("t3_done_latency", at - t0, 3);
        chk("t3_d_rdata_kept", bus.d_rdata, 32'hA5A50001);
        step();
        bus.d_req = 0; bus.d_we = 0;

        // 4: memory never answers; watchdog aborts after TO request cycles
        step();
        mem_waits = 1000;
        bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'h400;
        t0 = cyc; r0 = req_cycles;
        wait_done(1, 20, at);
        chk("t4_done_latency", at - t0, 5);
        chk("t4_bus_err", bus.bus_err, 1);
        chk("t4_d_rdata_zero", bus.d_rdata, 0);
        chk("t4_req_cycles", req_cycles - r0, 4);
        step();
        bus.d_req = 0;

        // 5: reset during the second BUSY cycle of a fetch
        step();
        mem_waits = 10;
        bus.if_req = 1; bus.if_addr = 32'h500;
        step();
        step();
        rst = 1'b1; bus.if_req = 0;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_mem_req", bus.mem_req, 0);
        chk("t5_mem_addr", bus.mem_addr, 0);
        chk("t5_if_rdata", bus.if_rdata, 0);
        chk("t5_d_rdata", bus.d_rdata, 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.if_done) seen++;
        end
        chk("t5_no_if_done", seen, 0);

        // stray mem_ready while idle must do nothing
        step();
        force_rdy = 1'b1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.if_done || bus.d_done || bus.mem_req) seen++;
        end
        chk("stray_ready_ignored", seen, 0);
        step();
        force_rdy = 1'b0;

        // 6: back-to-back zero-wait fetches, request held high throughout
        step();
        mem_waits = 0;
        t0 = cyc;
        for (int k = 0; k < 3; k++) begin
            mem_data = 32'hF0000000 + k;
            bus.if_req = 1; bus.if_addr = k * 4;
            wait_done(0, 20, at);
            chk("t6_if_latency", at - t0, 2 + 3 * k);
            chk("t6_if_rdata", bus.if_rdata, 32'hF0000000 + k);
            step();
        end
        bus.if_req = 0;

        step();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end
endmodule
